// File: rtl/io_pkg.sv
// Shared IO address map, status bit positions and UART state encoding.
// Used by io_responder and by memory-stage control when routing IO accesses.
package io_pkg;
    localparam logic [31:0] IO_STATUS_ADDR = 32'h8000_0000;
    localparam logic [31:0] IO_RXDATA_ADDR = 32'h8000_0004;
    localparam logic [31:0] IO_TXDATA_ADDR = 32'h8000_0008;
    localparam logic [31:0] IO_CYCLE_ADDR  = 32'h8000_0010;
    localparam logic [31:0] IO_CYCCLR_ADDR = 32'h8000_0018;

    localparam int STAT_TX_READY_BIT = 0;
    localparam int STAT_RX_VALID_BIT = 1;

    typedef enum logic [1:0] {
        UART_IDLE,
        UART_START,
        UART_DATA,
        UART_STOP
    } uart_state_e;
endpackage

// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter: START -> 8 data bits LSB first -> STOP, each CPB cycles.
// ready is high only in IDLE; a start pulse while busy is ignored.
module uart_transmitter
    import io_pkg::*;
#(
    parameter int CPB = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data,
    output logic       ready,
    output logic       serial_out
);
    localparam int CW = $clog2(CPB + 1);

    uart_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= UART_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    // tx_d is the line level for the cycle after the edge, so the line is a clean flop.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        case (state_q)
            UART_IDLE: begin
                tx_d = 1'b1;
                if (start) begin
                    state_d = UART_START;
                    cnt_d   = '0;
                    shift_d = data;
                    tx_d    = 1'b0;
                end
            end
            UART_START: begin
                if (cnt_q == CW'(CPB - 1)) begin
                    state_d = UART_DATA;
                    cnt_d   = '0;
                    idx_d   = '0;
                    tx_d    = shift_q[0];
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            UART_DATA: begin
                if (cnt_q == CW'(CPB - 1)) begin
                    cnt_d   = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (idx_q == 3'd7) begin
                        state_d = UART_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        idx_d = idx_q + 3'd1;
                        tx_d  = shift_q[1];
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            UART_STOP: begin
                if (cnt_q == CW'(CPB - 1)) begin
                    state_d = UART_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = UART_IDLE;
        endcase
    end

    assign ready      = (state_q == UART_IDLE);
    assign serial_out = tx_q;
endmodule

// File: rtl/io_responder.sv
// Memory-mapped UART responder: status / rx data / tx data registers, UART RX here.
// Define IO_COUNTERS_EN to add the free-running cycle counter at 0x80000010.
module io_responder
    import io_pkg::*;
#(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD_RATE  = 115_200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [3:0]  we,
    input  logic [31:0] addr,
    input  logic [31:0] din,
    output logic [31:0] dout,
    input  logic        serial_in,
    output logic        serial_out
);
    localparam int CPB  = CLOCK_FREQ / BAUD_RATE;
    localparam int HALF = CPB / 2;
    localparam int CW   = $clog2(CPB + 1);

    logic        rd, wr, tx_start, tx_ready, rx_pop, rx_s;
    logic        unused_din;
    logic [1:0]  sync_q, sync_d;
    logic [31:0] dout_q, dout_d;

    uart_state_e   rx_state_q, rx_state_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]    rx_idx_q, rx_idx_d;
    logic [7:0]    rx_shift_q, rx_shift_d;
    logic [7:0]    rx_data_q, rx_data_d;
    logic          rx_valid_q, rx_valid_d;

    assign rd         = en && (we == 4'b0000);
    assign wr         = en && (we != 4'b0000);
    assign tx_start   = wr && (addr == IO_TXDATA_ADDR) && tx_ready;
    assign rx_pop     = rd && (addr == IO_RXDATA_ADDR);
    assign rx_s       = sync_q[1];
    assign sync_d     = {sync_q[0], serial_in};
    assign unused_din = ^din[31:8];

    uart_transmitter #(.CPB(CPB)) u_tx (
        .clk        (clk),
        .rst        (rst),
        .start      (tx_start),
        .data       (din[7:0]),
        .ready      (tx_ready),
        .serial_out (serial_out)
    );

`ifdef IO_COUNTERS_EN
    // Holds 0 the cycle after the clearing write, so a read sampled k edges later returns k-1.
    logic [31:0] cyc_q, cyc_d;
    assign cyc_d = (wr && (addr == IO_CYCCLR_ADDR)) ? 32'd0 : cyc_q + 32'd1;
    always_ff @(posedge clk) begin
        if (rst) cyc_q <= '0;
        else     cyc_q <= cyc_d;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q     <= 2'b11;
            dout_q     <= '0;
            rx_state_q <= UART_IDLE;
            rx_cnt_q   <= '0;
            rx_idx_q   <= '0;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            dout_q     <= dout_d;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_idx_q   <= rx_idx_d;
            rx_shift_q <= rx_shift_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
        end
    end

    always_comb begin
        dout_d = '0;
        if (rd) begin
            case (addr)
                IO_STATUS_ADDR: begin
                    dout_d[STAT_TX_READY_BIT] = tx_ready;
                    dout_d[STAT_RX_VALID_BIT] = rx_valid_q;
                end
                IO_RXDATA_ADDR: dout_d = {24'd0, rx_data_q};
`ifdef IO_COUNTERS_EN
                IO_CYCLE_ADDR:  dout_d = cyc_q;
`endif
                default:        dout_d = '0;
            endcase
        end
    end

    // Byte completion is evaluated after the pop so a simultaneous new byte keeps rx_valid set.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_idx_d   = rx_idx_q;
        rx_shift_d = rx_shift_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        if (rx_pop) rx_valid_d = 1'b0;
        case (rx_state_q)
            UART_IDLE: begin
                if (!rx_s) begin
                    rx_state_d = UART_START;
                    rx_cnt_d   = '0;
                end
            end
            UART_START: begin
                if (rx_cnt_q == CW'(HALF)) begin
                    rx_cnt_d   = '0;
                    rx_idx_d   = '0;
                    rx_state_d = rx_s ? UART_IDLE : UART_DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + CW'(1);
                end
            end
            UART_DATA: begin
                if (rx_cnt_q == CW'(CPB - 1)) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_s, rx_shift_q[7:1]};
                    if (rx_idx_q == 3'd7) rx_state_d = UART_STOP;
                    else                  rx_idx_d   = rx_idx_q + 3'd1;
                end else begin
                    rx_cnt_d = rx_cnt_q + CW'(1);
                end
            end
            UART_STOP: begin
                if (rx_cnt_q == CW'(CPB - 1)) begin
                    rx_cnt_d   = '0;
                    rx_state_d = UART_IDLE;
                    rx_data_d  = rx_shift_q;
                    rx_valid_d = 1'b1;
                end else begin
                    rx_cnt_d = rx_cnt_q + CW'(1);
                end
            end
            default: rx_state_d = UART_IDLE;
        endcase
    end

    assign dout = dout_q;
endmodule
